// File: rtl/mem_line_ctrl_pkg.sv
// Shared constants and FSM encoding for the line-to-byte memory port.
// Default widths: 20-bit physical address, byte data, 16-byte lines.
package mem_line_ctrl_pkg;

  localparam int BYTE       = 8;
  localparam int PA_BITS    = 20;
  localparam int LINE_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    WB    = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Line request/response handshake plus the byte-wide memory bus.
// slave: the line controller; master: cache side and memory responder.
interface mem_line_ctrl_if #(
  parameter int PA_WIDTH    = mem_line_ctrl_pkg::PA_BITS,
  parameter int WIDTH       = mem_line_ctrl_pkg::BYTE,
  parameter int BLOCK_BYTES = mem_line_ctrl_pkg::LINE_BYTES
);

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_wr;
  logic [PA_WIDTH-1:0]          req_addr;
  logic [BLOCK_BYTES*WIDTH-1:0] req_line;
  logic                         resp_valid;
  logic [BLOCK_BYTES*WIDTH-1:0] resp_line;
  logic                         busy;
  logic [PA_WIDTH-1:0]          mem_addr;
  logic                         mem_rd_en;
  logic                         mem_wr_en;
  logic [WIDTH-1:0]             mem_wr_data;
  logic [WIDTH-1:0]             mem_rd_data;

  modport slave (
    input  req_valid, req_wr, req_addr, req_line,
    input  mem_rd_data,
    output req_ready, resp_valid, resp_line, busy,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
    output req_valid, req_wr, req_addr, req_line,
    output mem_rd_data,
    input  req_ready, resp_valid, resp_line, busy,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

endinterface

// File: rtl/mem_line_buf.sv
// Cache-line register: full-line parallel load, byte write, line read.
// Ports: clk, load/load_line, wr_en/wr_idx/wr_data, line.
module mem_line_buf
  import mem_line_ctrl_pkg::*;
#(
  parameter int WIDTH       = BYTE,
  parameter int BLOCK_BYTES = LINE_BYTES
) (
  input  logic                          clk,
  input  logic                          load,
  input  logic [BLOCK_BYTES*WIDTH-1:0]  load_line,
  input  logic                          wr_en,
  input  logic [$clog2(BLOCK_BYTES)-1:0] wr_idx,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [BLOCK_BYTES-1:0][WIDTH-1:0] line
);

  logic [BLOCK_BYTES-1:0][WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_line;
    end else if (wr_en) begin
      q[wr_idx] <= wr_data;
    end
  end

  assign line = q;

endmodule

// File: rtl/mem_line_ctrl.sv
// Turns one line fill/writeback into BLOCK_BYTES byte accesses.
// Ports: clk, rst (sync, active high), bus (mem_line_ctrl_if.slave).
module mem_line_ctrl
  import mem_line_ctrl_pkg::*;
#(
  parameter int PA_WIDTH    = PA_BITS,
  parameter int WIDTH       = BYTE,
  parameter int BLOCK_BYTES = LINE_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  mem_line_ctrl_if.slave  bus
);

  localparam int OFF = $clog2(BLOCK_BYTES);
  localparam int HI  = PA_WIDTH - OFF;

  typedef logic [OFF-1:0] idx_t;
  localparam idx_t LAST = idx_t'(BLOCK_BYTES - 1);

  state_t        state;
  idx_t          cnt;
  idx_t          cnt_nx;
  logic [HI-1:0] base_hi;
  logic          accept;
  logic          buf_wr;
  idx_t          buf_idx;

  logic [BLOCK_BYTES-1:0][WIDTH-1:0] line;
  logic [BLOCK_BYTES-1:0][WIDTH-1:0] fill_line;

  assign bus.req_ready = (state == IDLE);
  assign accept = bus.req_valid && bus.req_ready;
  assign cnt_nx = cnt + idx_t'(1);

  // Read data lags its strobe by one cycle, so FILL
  // stores byte cnt-1 and DRAIN stores the last byte.
  always_comb begin
    buf_wr  = 1'b0;
    buf_idx = cnt - idx_t'(1);
    if (state == FILL && cnt != '0) begin
      buf_wr = 1'b1;
    end
    if (state == DRAIN) begin
      buf_wr  = 1'b1;
      buf_idx = cnt;
    end
  end

  // The last byte lands in the buffer on the same edge
  // that loads resp_line, so merge it in directly.
  always_comb begin
    fill_line       = line;
    fill_line[LAST] = bus.mem_rd_data;
  end

  mem_line_buf #(
    .WIDTH       (WIDTH),
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_buf (
    .clk       (clk),
    .load      (accept && !rst),
    .load_line (bus.req_line),
    .wr_en     (buf_wr && !rst),
    .wr_idx    (buf_idx),
    .wr_data   (bus.mem_rd_data),
    .line      (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      base_hi         <= '0;
      bus.busy        <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_line   <= '0;
      bus.mem_addr    <= '0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            base_hi      <= bus.req_addr[PA_WIDTH-1:OFF];
            cnt          <= '0;
            bus.busy     <= 1'b1;
            bus.mem_addr <= {bus.req_addr[PA_WIDTH-1:OFF],
                             {OFF{1'b0}}};
            if (bus.req_wr) begin
              state           <= WB;
              bus.mem_wr_en   <= 1'b1;
              bus.mem_wr_data <= bus.req_line[WIDTH-1:0];
            end else begin
              state         <= FILL;
              bus.mem_rd_en <= 1'b1;
            end
          end
        end
        FILL: begin
          if (cnt == LAST) begin
            state         <= DRAIN;
            bus.mem_rd_en <= 1'b0;
          end else begin
            cnt          <= cnt_nx;
            bus.mem_addr <= {base_hi, cnt_nx};
          end
        end
        DRAIN: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_line  <= fill_line;
        end
        WB: begin
          if (cnt == LAST) begin
            state          <= RESP;
            bus.mem_wr_en  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_line  <= line;
          end else begin
            cnt             <= cnt_nx;
            bus.mem_addr    <= {base_hi, cnt_nx};
            bus.mem_wr_data <= line[cnt_nx];
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Self-checking bench for mem_line_ctrl with a byte memory responder.
// Reference model: per-byte memory image plus latency arithmetic.
module tb_mem_line_ctrl;
  import mem_line_ctrl_pkg::*;

  localparam int N = LINE_BYTES;
  typedef logic [N*8-1:0] line_t;
  typedef bit [19:0] addr_t;

  typedef struct {
    int    cyc;
    bit    wr;
    addr_t addr;
    bit [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_line_ctrl_if bus();

  mem_line_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int overlap = 0;
  int ready_bad = 0;

  logic [7:0] mem   [addr_t];
  logic [7:0] ref_m [addr_t];

  ev_t   ev_q[$];
  int    acc_q[$];
  int    resp_q[$];
  line_t rline_q[$];

  function automatic logic [7:0] init_byte(addr_t a);
    return 8'(a[7:0] * 3) ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(addr_t a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(addr_t a);
    return ref_m.exists(a) ? ref_m[a] : init_byte(a);
  endfunction

  function automatic line_t ref_line(addr_t base);
    line_t l;
    for (int k = 0; k < N; k++) l[k*8 +: 8] = ref_rd(base + addr_t'(k));
    return l;
  endfunction

  function automatic line_t mem_line(addr_t base);
    line_t l;
    for (int k = 0; k < N; k++) l[k*8 +: 8] = mem_rd(base + addr_t'(k));
    return l;
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < N; k++) l[k*8 +: 8] = 8'($urandom);
    return l;
  endfunction

  function automatic addr_t align(addr_t a);
    return a & ~addr_t'(N - 1);
  endfunction

  // Count strobes starting at queue index s that differ from the
  // expected one-byte-per-cycle sequence after an accept at edge a.
  function automatic int seq_bad(int s, int a, bit wr,
                                 addr_t base, line_t l);
    int  bad;
    ev_t e;
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if (s + k >= ev_q.size()) begin
        bad++;
      end else begin
        e = ev_q[s + k];
        if (e.cyc != a + k + 1 || e.wr != wr ||
            e.addr != base + addr_t'(k) ||
            (wr && e.data != l[k*8 +: 8]))
          bad++;
      end
    end
    return bad;
  endfunction

  // Memory responder: registered read, write on the strobe edge.
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_rd(bus.mem_addr);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd_en || bus.mem_wr_en)
        ev_q.push_back('{cyc, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data});
      if (bus.mem_rd_en && bus.mem_wr_en) overlap++;
      if (bus.busy == bus.req_ready) ready_bad++;
      if (bus.resp_valid) begin
        resp_q.push_back(cyc);
        rline_q.push_back(bus.resp_line);
      end
    end
  end

  task automatic clear_logs();
    ev_q.delete();
    acc_q.delete();
    resp_q.delete();
    rline_q.delete();
  endtask

  task automatic issue(input bit wr, input addr_t a,
                       input line_t l, output bit ok);
    int n0;
    n0 = acc_q.size();
    ok = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_line  = l;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (acc_q.size() > n0) ok = 1'b1;
    end
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'($urandom);
    bus.req_addr  = 20'($urandom);
    bus.req_line  = rand_line();
  endtask

  task automatic wait_resp(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 80 && !ok; t++) begin
      @(negedge clk);
      if (resp_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b resp_valid=%b want 0 0",
               bus.busy, bus.resp_valid);
    end
    checks++;
    if (bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes rd=%b wr=%b want 0 0",
               bus.mem_rd_en, bus.mem_wr_en);
    end
    checks++;
    if (bus.mem_addr !== 20'h0 || bus.mem_wr_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_bus addr=%h data=%h want 0 0",
               bus.mem_addr, bus.mem_wr_data);
    end
    checks++;
    if (bus.resp_line !== line_t'(0)) begin
      errors++;
      $display("FAIL reset_line got %h want 0", bus.resp_line);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready ready=%b busy=%b want 1 0",
               bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_fill();
    bit ok;
    line_t exp;
    clear_logs();
    for (int k = 0; k < N; k++) begin
      mem[20'h00120 + addr_t'(k)]   = 8'hA0 + 8'(k);
      ref_m[20'h00120 + addr_t'(k)] = 8'hA0 + 8'(k);
    end
    for (int k = 0; k < N; k++) exp[k*8 +: 8] = 8'hA0 + 8'(k);
    issue(1'b0, 20'h00127, rand_line(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_accept timeout got 0 want 1");
    end
    wait_resp(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_resp timeout got 0 want 1");
    end
    checks++;
    if (ev_q.size() !== N ||
        seq_bad(0, acc_q[0], 1'b0, 20'h00120, '0) !== 0) begin
      errors++;
      $display("FAIL fill_seq strobes=%0d bad=%0d want %0d 0",
               ev_q.size(), seq_bad(0, acc_q[0], 1'b0, 20'h00120, '0), N);
    end
    checks++;
    if (resp_q[0] - acc_q[0] !== N + 2) begin
      errors++;
      $display("FAIL fill_latency got %0d want %0d",
               resp_q[0] - acc_q[0], N + 2);
    end
    checks++;
    if (rline_q[0] !== exp) begin
      errors++;
      $display("FAIL fill_line got %h want %h", rline_q[0], exp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.resp_line !== exp || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_hold line=%h v=%b want %h 0",
               bus.resp_line, bus.resp_valid, exp);
    end
  endtask

  task automatic test_writeback();
    bit ok;
    line_t l;
    line_t exp;
    for (int k = 0; k < N; k++) l[k*8 +: 8] = 8'h10 + 8'(k);
    clear_logs();
    issue(1'b1, 20'h00300, l, ok);
    for (int k = 0; k < N; k++)
      ref_m[20'h00300 + addr_t'(k)] = l[k*8 +: 8];
    wait_resp(1, ok);
    checks++;
    if (!ok || ev_q.size() !== N ||
        seq_bad(0, acc_q[0], 1'b1, 20'h00300, l) !== 0) begin
      errors++;
      $display("FAIL wb_seq strobes=%0d resp=%b want %0d 1",
               ev_q.size(), ok, N);
    end
    checks++;
    if (resp_q[0] - acc_q[0] !== N + 1) begin
      errors++;
      $display("FAIL wb_latency got %0d want %0d",
               resp_q[0] - acc_q[0], N + 1);
    end
    checks++;
    if (rline_q[0] !== l) begin
      errors++;
      $display("FAIL wb_line got %h want %h", rline_q[0], l);
    end
    clear_logs();
    issue(1'b0, 20'h00300, rand_line(), ok);
    wait_resp(1, ok);
    exp = ref_line(20'h00300);
    checks++;
    if (!ok || rline_q[0] !== exp) begin
      errors++;
      $display("FAIL wb_readback got %h want %h", rline_q[0], exp);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    addr_t a;
    addr_t b;
    line_t l;
    line_t exp;
    a = align(20'($urandom));
    b = a ^ 20'h40000;
    l = rand_line();
    exp = ref_line(a);
    clear_logs();
    overlap = 0;
    ready_bad = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = a;
    for (int t = 0; t < 10 && acc_q.size() < 1; t++) @(negedge clk);
    bus.req_wr   = 1'b1;
    bus.req_addr = b;
    bus.req_line = l;
    for (int t = 0; t < 60 && acc_q.size() < 2; t++) @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < N; k++) ref_m[b + addr_t'(k)] = l[k*8 +: 8];
    wait_resp(2, ok);
    checks++;
    if (!ok || acc_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count acc=%0d resp=%0d want 2 2",
               acc_q.size(), resp_q.size());
    end else begin
      checks++;
      if (acc_q[1] - resp_q[0] !== 1) begin
        errors++;
        $display("FAIL b2b_gap got %0d want 1", acc_q[1] - resp_q[0]);
      end
      checks++;
      if (seq_bad(0, acc_q[0], 1'b0, a, '0) +
          seq_bad(N, acc_q[1], 1'b1, b, l) !== 0) begin
        errors++;
        $display("FAIL b2b_seq bad strobes, want 0");
      end
      checks++;
      if (rline_q[0] !== exp || rline_q[1] !== l) begin
        errors++;
        $display("FAIL b2b_lines got %h %h want %h %h",
                 rline_q[0], rline_q[1], exp, l);
      end
    end
    checks++;
    if (overlap !== 0 || ready_bad !== 0) begin
      errors++;
      $display("FAIL b2b_excl overlap=%0d ready_bad=%0d want 0 0",
               overlap, ready_bad);
    end
  endtask

  task automatic test_top_line();
    bit ok;
    line_t exp;
    exp = ref_line(20'hFFFF0);
    clear_logs();
    issue(1'b0, 20'hFFFF0 | 20'($urandom_range(N - 1)), rand_line(), ok);
    wait_resp(1, ok);
    checks++;
    if (!ok || ev_q.size() !== N ||
        seq_bad(0, acc_q[0], 1'b0, 20'hFFFF0, '0) !== 0) begin
      errors++;
      $display("FAIL top_seq strobes=%0d last=%h want %0d fffff",
               ev_q.size(), bus.mem_addr, N);
    end
    checks++;
    if (rline_q[0] !== exp) begin
      errors++;
      $display("FAIL top_line got %h want %h", rline_q[0], exp);
    end
  endtask

  task automatic test_reset_mid_wb();
    bit ok;
    addr_t base;
    line_t l;
    line_t old;
    line_t exp;
    base = align(20'($urandom)) | 20'h08000;
    l = rand_line();
    old = ref_line(base);
    exp = old;
    for (int k = 0; k < 5; k++) exp[k*8 +: 8] = l[k*8 +: 8];
    clear_logs();
    issue(1'b1, base, l, ok);
    #1;
    for (int t = 0; t < 40 && ev_q.size() < 5; t++) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ctrl busy=%b v=%b rd=%b wr=%b rdy=%b want 00001",
               bus.busy, bus.resp_valid, bus.mem_rd_en,
               bus.mem_wr_en, bus.req_ready);
    end
    checks++;
    if (bus.mem_addr !== 20'h0 || bus.mem_wr_data !== 8'h0 ||
        bus.resp_line !== line_t'(0)) begin
      errors++;
      $display("FAIL rst_bus addr=%h data=%h line=%h want 0",
               bus.mem_addr, bus.mem_wr_data, bus.resp_line);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) ref_m[base + addr_t'(k)] = l[k*8 +: 8];
    repeat (25) @(negedge clk);
    checks++;
    if (resp_q.size() !== 0 || ev_q.size() !== 5) begin
      errors++;
      $display("FAIL rst_abort resp=%0d strobes=%0d want 0 5",
               resp_q.size(), ev_q.size());
    end
    checks++;
    if (mem_line(base) !== exp) begin
      errors++;
      $display("FAIL rst_mem got %h want %h", mem_line(base), exp);
    end
  endtask

  task automatic test_busy_req();
    bit ok;
    addr_t a;
    line_t exp;
    a = align(20'($urandom));
    exp = ref_line(a);
    clear_logs();
    issue(1'b0, a, rand_line(), ok);
    repeat (4) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'($urandom);
    bus.req_addr  = a ^ 20'h00550;
    bus.req_line  = rand_line();
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_resp(1, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || acc_q.size() !== 1 || resp_q.size() !== 1) begin
      errors++;
      $display("FAIL busy_ignore acc=%0d resp=%0d want 1 1",
               acc_q.size(), resp_q.size());
    end
    checks++;
    if (ev_q.size() !== N ||
        seq_bad(0, acc_q[0], 1'b0, a, '0) !== 0 ||
        rline_q[0] !== exp) begin
      errors++;
      $display("FAIL busy_orig line=%h want %h", rline_q[0], exp);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit wr;
    addr_t a;
    addr_t base;
    line_t l;
    line_t exp;
    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom);
      a = (i % 4 == 3) ? (20'hFFFF0 | 20'($urandom_range(15)))
                       : 20'($urandom);
      base = align(a);
      l = rand_line();
      exp = wr ? l : ref_line(base);
      clear_logs();
      issue(wr, a, l, ok);
      if (wr)
        for (int k = 0; k < N; k++) ref_m[base + addr_t'(k)] = l[k*8 +: 8];
      wait_resp(1, ok);
      checks++;
      if (!ok || ev_q.size() !== N ||
          seq_bad(0, acc_q[0], wr, base, l) !== 0) begin
        errors++;
        $display("FAIL rand_seq op=%0d wr=%b strobes=%0d want %0d",
                 i, wr, ev_q.size(), N);
      end
      checks++;
      if (resp_q[0] - acc_q[0] !== (wr ? N + 1 : N + 2) ||
          rline_q[0] !== exp) begin
        errors++;
        $display("FAIL rand_resp op=%0d lat=%0d line=%h want %0d %h",
                 i, resp_q[0] - acc_q[0], rline_q[0],
                 wr ? N + 1 : N + 2, exp);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_line  = '0;
    test_reset();
    test_fill();
    test_writeback();
    test_back_to_back();
    test_top_line();
    test_reset_mid_wb();
    test_busy_req();
    test_random();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL strobe_overlap got %0d want 0", overlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_line_ctrl.md
Name: mem_line_ctrl

Overview:
Initiator side of the byte-wide main-memory port. It converts one cache-line request (fill or writeback) from the cache controller into a sequence of BLOCK_BYTES single-byte read or write accesses on the memory's addr/rd_en/wr_en/wr_data/rd_data interface. It assembles read bytes into a full line and returns it. It sits between the cache controller and the main memory array.

Parameters:
PA_WIDTH, `PA_WIDTH (20), physical address width; matches the memory address port.
WIDTH, `BYTE (8), memory data width in bits.
BLOCK_BYTES, 16, bytes per cache line; must be a power of two and at least 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  line request is present.
req_ready  output  1  block can accept a request; high only in IDLE.
req_wr  input  1  request type: 1 = writeback, 0 = fill.
req_addr  input  PA_WIDTH  line address; the low log2(BLOCK_BYTES) bits are ignored.
req_line  input  BLOCK_BYTES*WIDTH  writeback data; byte 0 is in bits [WIDTH-1:0].
resp_valid  output  1  one-cycle completion pulse.
resp_line  output  BLOCK_BYTES*WIDTH  on a fill, the assembled line; on a writeback, the written line.
busy  output  1  high whenever the state is not IDLE.
mem_addr  output  PA_WIDTH  byte address to memory.
mem_rd_en  output  1  memory read strobe.
mem_wr_en  output  1  memory write strobe.
mem_wr_data  output  WIDTH  memory write byte.
mem_rd_data  input  WIDTH  memory read byte; registered in memory, valid one cycle after mem_rd_en.

Behaviour:
- States: IDLE, FILL, DRAIN, WB, RESP. In reset, state goes to IDLE and busy, resp_valid, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, resp_line and the byte counter all clear to 0. req_ready is 1 in the first cycle after reset.
- Accept: on a clock edge with req_valid && req_ready, latch the base address (req_addr with low bits zeroed), req_wr and req_line. Clear the counter i. Go to WB if req_wr is 1, otherwise FILL. A req_valid seen while not IDLE is ignored; no queueing.
- FILL, for N = BLOCK_BYTES cycles:
  - mem_rd_en = 1, mem_addr = base + i, i increments each cycle.
  - On each edge where the previous cycle issued a read, capture mem_rd_data into line byte i-1.
  - After i = N-1, go to DRAIN.
- DRAIN, 1 cycle: mem_rd_en = 0. Capture byte N-1, then go to RESP.
- WB, for N cycles:
  - mem_wr_en = 1, mem_addr = base + i, mem_wr_data = latched line byte i.
  - After i = N-1, go to RESP.
- RESP, 1 cycle: resp_valid = 1 and resp_line holds the line, then return to IDLE. There is no backpressure on the response; the consumer must take it in that cycle.
- resp_line keeps its value after RESP until the next RESP.
- Latency, with the accept edge as cycle 0:
  - Fill: strobes in cycles 1..N, DRAIN in cycle N+1, resp_valid in cycle N+2.
  - Writeback: strobes in cycles 1..N, resp_valid in cycle N+1.
  - The next accept is possible in the cycle after RESP.
- mem_rd_en and mem_wr_en are never high in the same cycle. Both are 0 in IDLE, DRAIN and RESP.
- Addressing never crosses a line: the base is aligned, so base + i only changes the low bits. The top line of memory (all-ones upper address bits) is legal.
- Counter width is $clog2(BLOCK_BYTES). The counter must not wrap within an operation.
- Reset mid-operation: abort immediately to IDLE with no resp_valid. Memory bytes already written stay written. A partial fill line is discarded.
- req_addr and req_line may change after the accept edge without effect.

Decomposition:
- Add to the shared macros.v: `BYTE, `PA_WIDTH, `BLOCK_BYTES, and the state encodings (3-bit localparams: IDLE=0, FILL=1, DRAIN=2, WB=3, RESP=4).
- One natural sub-module: mem_line_buf, the BLOCK_BYTES x WIDTH line register with a byte-indexed write port and full-line parallel load and read. It is shared later by the cache data path.
- The bench instantiates the existing main-memory model with INIT=1 as the responder.

Test Plan:
1. Fill with BLOCK_BYTES=16: preload memory[0x00120+k] = 0xA0+k, request req_wr=0, req_addr=0x00127 -> mem_addr sequences 0x00120..0x0012F, resp_valid in cycle 18, resp_line bytes 0..15 = 0xA0..0xAF.
2. Writeback: req_wr=1, req_addr=0x00300, req_line byte k = 0x10+k -> 16 write strobes, resp_valid in cycle 17, then a fill of 0x00300 returns 0x10..0x1F.
3. Back-to-back: assert req_valid continuously with fill then writeback -> req_ready low through RESP, second accept in the cycle after resp_valid, no overlapping strobes.
4. Top line: fill at 0xFFFF0 -> addresses 0xFFFF0..0xFFFFF with no wrap to 0x00000, correct data returned.
5. Reset mid-writeback: assert rst after the 5th write strobe -> next cycle idle with all outputs 0, bytes 0..4 written in memory, bytes 5..15 unchanged, no resp_valid.
6. Request while busy: pulse req_valid during FILL with a different address -> ignored, only the original request completes.
